mult_seq64: RTL
===============

MULT_SEQ64 -- requirements
Module: mult_seq64

Interface
REQ-001 Parameter WIDTH, default 64: operand and result-half width; iteration count equals WIDTH.
REQ-002 Port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-005 Port flush  input  1  abort any operation in progress (pipeline squash).
REQ-006 Port a  input  WIDTH  multiplicand, unsigned; captured when start is accepted.
REQ-007 Port b  input  WIDTH  multiplier, unsigned; captured when start is accepted.
REQ-008 Port lo  output  WIDTH  low half of the product (MUL result); feeds the result-select mux.
REQ-009 Port hi  output  WIDTH  high half of the unsigned product (UMULH result).
REQ-010 Port busy  output  1  high while in BUSY.
REQ-011 Port done  output  1  one-cycle pulse marking lo/hi valid for a new result.

Function
REQ-012 The block SHALL implement a radix-2 shift-add multiplier with states IDLE, BUSY and DONE.
REQ-013 In IDLE or DONE, when start=1 and flush=0 at an edge, the block SHALL capture a and b, clear the 2*WIDTH accumulator and the iteration counter, and enter BUSY.
REQ-014 In BUSY, each edge SHALL perform one iteration: add the multiplicand to the upper half if the current multiplier LSB is 1, shift the {carry, accumulator} pair right by one, and increment the counter.
REQ-015 The carry out of the WIDTH-bit add SHALL be retained into the shift so the product is exact to 2*WIDTH bits.
REQ-016 After the WIDTH-th iteration the block SHALL enter DONE.
REQ-017 Latency: if start is accepted at edge E0, then done=1 SHALL hold exactly for the cycle between E(WIDTH) and E(WIDTH+1), i.e. 64 cycles for the default.
REQ-018 The latency SHALL be fixed, with no early termination for zero or small operands.
REQ-019 busy SHALL be 1 exactly while in BUSY; done SHALL be 1 exactly while in DONE; they are never both 1.
REQ-020 From DONE, the block SHALL return to IDLE at the next edge unless a start is accepted (back-to-back operation, next done after WIDTH more cycles).
REQ-021 lo and hi SHALL present the completed product from entry to DONE until the next accepted start, and SHALL hold that value through IDLE.
REQ-022 During BUSY, lo and hi SHALL be treated as don't-care by consumers.
REQ-023 start asserted during BUSY SHALL be ignored: no restart, operands unchanged.
REQ-024 flush=1 at an edge SHALL force IDLE from any state, suppress done, and leave lo/hi at their last completed value (outputs must not change to a partial product).
REQ-025 flush SHALL take priority over start at the same edge.
REQ-026 Signed MUL uses lo directly, since the low half is sign-agnostic; signed high-half products are out of scope.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, busy=0, done=0, lo=0, hi=0, and counter=0, overriding start and flush, including mid-operation.
REQ-028 The first start sampled after reset deasserts SHALL be accepted normally.

Verification
REQ-029 a=3, b=5, start pulse -> busy for 64 cycles, then done pulse; lo=15, hi=0.
REQ-030 a=b=0xFFFF_FFFF_FFFF_FFFF -> lo=0x0000_0000_0000_0001, hi=0xFFFF_FFFF_FFFF_FFFE (exercises the carry path).
REQ-031 a=-2418 (0xFFFF_FFFF_FFFF_F68E), b=10 -> lo=0xFFFF_FFFF_FFFF_A18C (-24180), hi=9; start held high during BUSY causes no restart.
REQ-032 Back-to-back: start=1 in the DONE cycle with a=100, b=64 -> second done exactly 64 cycles later, lo=6400; the first result (15) is held until the second start is accepted.
REQ-033 Flush at iteration 30 of a=10000, b=1 -> IDLE next cycle, no done, lo/hi retain the previous result; same-edge start+flush in IDLE -> stays IDLE.
REQ-034 Reset at iteration 40 -> next cycle busy=0, done=0, lo=hi=0; a subsequent 7*6 operation gives lo=42 after 64 cycles.

Source files
------------

// File: rtl/mult_seq64.sv
// mult_seq64: radix-2 shift-add unsigned multiplier, one iteration per clock.
// Ports:
//   clk, reset    - single clock, synchronous active-high reset
//   start, flush  - request a multiply (IDLE/DONE only); abort to IDLE
//   a, b          - unsigned operands, captured when start is accepted
//   lo, hi        - low/high halves of the last completed 2*WIDTH product
//   busy, done    - high in BUSY; one-cycle pulse when a new result is valid
module mult_seq64 #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned SUM_W = WIDTH + 1;
   localparam int unsigned ACC_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [ACC_W-1:0]   acc_q,    acc_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0]   lo_q,     lo_d;
   logic [WIDTH-1:0]   hi_q,     hi_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;

   logic [SUM_W-1:0]   sum_c;
   logic [ACC_W-1:0]   acc_next_c;

   // One iteration: conditional add into the upper half, keeping the carry,
   // then shift the {carry, accumulator} pair right by one.
   always_comb begin
      sum_c      = SUM_W'(acc_q[ACC_W-1:WIDTH])
                 + (mplier_q[0] ? SUM_W'(mcand_q) : SUM_W'(0));
      acc_next_c = {sum_c, acc_q[WIDTH-1:1]};
   end

   // Next-state and output logic; lo/hi only update on completion so a
   // flushed or in-flight operation never exposes a partial product.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_BUSY: begin
               acc_d    = acc_next_c;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = ST_DONE;
                  lo_d    = acc_next_c[WIDTH-1:0];
                  hi_d    = acc_next_c[ACC_W-1:WIDTH];
                  done_d  = 1'b1;
               end else begin
                  busy_d  = 1'b1;
               end
            end
            default: begin
               if (start) begin
                  state_d  = ST_BUSY;
                  mcand_d  = a;
                  mplier_d = b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign lo   = lo_q;
   assign hi   = hi_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
